alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter (with package alu_pkg and shared datapath alu)
// Brief    : Two-requester round-robin front end time-sharing one ALU.
//            Optional macro ALU_ARBITER_STATS_EN adds per-requester
//            saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_control_t;
endpackage

module alu #(
  parameter int N = 32
) (
  input  logic                 [N-1:0] a,
  input  logic                 [N-1:0] b,
  input  alu_pkg::alu_control_t        control,
  output logic                 [N-1:0] result,
  output logic                         overflow,
  output logic                         zero,
  output logic                         equal
);
  import alu_pkg::*;

  logic [N-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic         w_lt;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt   = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = w_sum;
        overflow = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = w_diff;
        overflow = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(N-1){1'b0}}, w_lt};
      default: result = '0;
    endcase
  end

  assign zero  = (result == '0);
  assign equal = (a == b);
endmodule

module alu_arbiter #(
  parameter int N = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic                 [N-1:0] req0_a,
  input  logic                 [N-1:0] req0_b,
  input  alu_pkg::alu_control_t        req0_control,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic                 [N-1:0] req1_a,
  input  logic                 [N-1:0] req1_b,
  input  alu_pkg::alu_control_t        req1_control,
  output logic                         rsp0_valid,
  input  logic                         rsp0_ready,
  output logic                 [N-1:0] rsp0_result,
  output logic                         rsp0_overflow,
  output logic                         rsp0_zero,
  output logic                         rsp0_equal,
  output logic                         rsp1_valid,
  input  logic                         rsp1_ready,
  output logic                 [N-1:0] rsp1_result,
  output logic                         rsp1_overflow,
  output logic                         rsp1_zero,
  output logic                         rsp1_equal,
`ifdef ALU_ARBITER_STATS_EN
  output logic                 [15:0]  grant_count0,
  output logic                 [15:0]  grant_count1,
`endif
  output logic                         busy
);
  import alu_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_prio;
  logic         r_id;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  alu_control_t r_control;

  logic         r_rsp_valid0, r_rsp_valid1;
  logic [N-1:0] r_result0, r_result1;
  logic         r_overflow0, r_overflow1;
  logic         r_zero0, r_zero1;
  logic         r_equal0, r_equal1;

  logic         w_gnt0, w_gnt1;
  logic         w_hs0, w_hs1;
  logic [N-1:0] w_result;
  logic         w_overflow, w_zero, w_equal;

`ifdef ALU_ARBITER_STATS_EN
  logic [15:0]  r_grant_count0;
  logic [15:0]  r_grant_count1;
  assign grant_count0 = r_grant_count0;
  assign grant_count1 = r_grant_count1;
`endif

  // The pointer only breaks ties; a lone valid requester always wins.
  assign w_gnt0 = req0_valid && (!req1_valid || !r_prio);
  assign w_gnt1 = req1_valid && (!req0_valid ||  r_prio);

  // rst_n gating keeps ready low during reset even though IDLE is forced.
  assign req0_ready = rst_n && (r_state == ST_IDLE) && w_gnt0;
  assign req1_ready = rst_n && (r_state == ST_IDLE) && w_gnt1;
  assign w_hs0      = req0_valid && req0_ready;
  assign w_hs1      = req1_valid && req1_ready;

  alu #(.N(N)) u_alu (
    .a        (r_a),
    .b        (r_b),
    .control  (r_control),
    .result   (w_result),
    .overflow (w_overflow),
    .zero     (w_zero),
    .equal    (w_equal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prio       <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_control    <= ALU_ADD;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_result0    <= '0;
      r_result1    <= '0;
      r_overflow0  <= 1'b0;
      r_overflow1  <= 1'b0;
      r_zero0      <= 1'b0;
      r_zero1      <= 1'b0;
      r_equal0     <= 1'b0;
      r_equal1     <= 1'b0;
`ifdef ALU_ARBITER_STATS_EN
      r_grant_count0 <= 16'd0;
      r_grant_count1 <= 16'd0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs0 || w_hs1) begin
            r_id      <= w_hs1;
            r_a       <= w_hs1 ? req1_a : req0_a;
            r_b       <= w_hs1 ? req1_b : req0_b;
            r_control <= w_hs1 ? req1_control : req0_control;
            r_prio    <= !w_hs1;
            r_state   <= ST_EXEC;
`ifdef ALU_ARBITER_STATS_EN
            if (w_hs0 && (r_grant_count0 != 16'hFFFF))
              r_grant_count0 <= r_grant_count0 + 16'd1;
            if (w_hs1 && (r_grant_count1 != 16'hFFFF))
              r_grant_count1 <= r_grant_count1 + 16'd1;
`endif
          end
        end
        ST_EXEC: begin
          if (r_id) begin
            r_rsp_valid1 <= 1'b1;
            r_result1    <= w_result;
            r_overflow1  <= w_overflow;
            r_zero1      <= w_zero;
            r_equal1     <= w_equal;
          end else begin
            r_rsp_valid0 <= 1'b1;
            r_result0    <= w_result;
            r_overflow0  <= w_overflow;
            r_zero0      <= w_zero;
            r_equal0     <= w_equal;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          // Clearing both channels keeps the idle channel's data at zero.
          if ((r_rsp_valid0 && rsp0_ready) || (r_rsp_valid1 && rsp1_ready)) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_result0    <= '0;
            r_result1    <= '0;
            r_overflow0  <= 1'b0;
            r_overflow1  <= 1'b0;
            r_zero0      <= 1'b0;
            r_zero1      <= 1'b0;
            r_equal0     <= 1'b0;
            r_equal1     <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp0_valid    = r_rsp_valid0;
  assign rsp0_result   = r_result0;
  assign rsp0_overflow = r_overflow0;
  assign rsp0_zero     = r_zero0;
  assign rsp0_equal    = r_equal0;
  assign rsp1_valid    = r_rsp_valid1;
  assign rsp1_result   = r_result1;
  assign rsp1_overflow = r_overflow1;
  assign rsp1_zero     = r_zero1;
  assign rsp1_equal    = r_equal1;
  assign busy          = (r_state != ST_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_pkg::*;

  localparam longint C_MAX = 64'sd2147483647;
  localparam longint C_MIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]  req0_a, req0_b, req1_a, req1_b;
  alu_control_t req0_control, req1_control;
  logic         rsp0_valid, rsp0_ready, rsp0_overflow, rsp0_zero, rsp0_equal;
  logic         rsp1_valid, rsp1_ready, rsp1_overflow, rsp1_zero, rsp1_equal;
  logic [31:0]  rsp0_result, rsp1_result;
  logic         busy;
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0]  grant_count0, grant_count1;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit m_prio   = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_control(req1_control),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero), .rsp0_equal(rsp0_equal),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero), .rsp1_equal(rsp1_equal),
`ifdef ALU_ARBITER_STATS_EN
    .grant_count0(grant_count0), .grant_count1(grant_count1),
`endif
    .busy(busy)
  );

  // Reference ALU computed in 64-bit signed arithmetic.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input int op, output logic [31:0] r,
                                  output logic ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      0: begin s = sa + sb; r = s[31:0]; ov = (s > C_MAX) || (s < C_MIN); end
      1: begin s = sa - sb; r = s[31:0]; ov = (s > C_MAX) || (s < C_MIN); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_control = ALU_ADD; req1_control = ALU_ADD;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_prio = 0;
  endtask

  // Presents one request and returns just after its handshake edge.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input alu_control_t op, output bit ok);
    ok = 0;
    @(negedge clk);
    if (k == 0) begin req0_valid = 1; req0_a = a; req0_b = b; req0_control = op; end
    else        begin req1_valid = 1; req1_a = a; req1_b = b; req1_control = op; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((k == 0) ? req0_ready : req1_ready) begin ok = 1; @(posedge clk); end
      else @(negedge clk);
    end
    #1;
    if (k == 0) req0_valid = 0; else req1_valid = 0;
    if (ok) m_prio = (k == 0);
  endtask

  // Counts falling edges until the channel's response appears.
  task automatic wait_rsp(input int k, output bit ok, output int cycles);
    ok = 0; cycles = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if ((k == 0) ? rsp0_valid : rsp1_valid) begin ok = 1; cycles = i + 1; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++; if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 5'b0)
      $display("FAIL reset_outputs: busy/rdy0/rdy1/rv0/rv1=%b required 00000",
               {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid}); else n_pass++;
    n_checks++; if ({rsp0_result, rsp1_result} !== 64'd0)
      $display("FAIL reset_data: got %h required 0", {rsp0_result, rsp1_result}); else n_pass++;
`ifdef ALU_ARBITER_STATS_EN
    n_checks++; if ({grant_count0, grant_count1} !== 32'd0)
      $display("FAIL reset_counts: got %h required 0", {grant_count0, grant_count1}); else n_pass++;
`endif
    @(negedge clk);
    idle_inputs();
    rst_n = 1; m_prio = 0;
  endtask

  task automatic test_overflow_add();
    bit ok; int cyc;
    rsp0_ready = 1;
    send(0, 32'h7FFFFFFF, 32'h00000001, ALU_ADD, ok);
    n_checks++; if (!ok) $display("FAIL ovf_grant: no handshake got 0 required 1"); else n_pass++;
    wait_rsp(0, ok, cyc);
    n_checks++; if (!ok || cyc != 2)
      $display("FAIL ovf_latency: edges %0d (seen %0d) required 2", cyc, ok); else n_pass++;
    n_checks++; if ({rsp0_result, rsp0_overflow, rsp0_zero, rsp0_equal} !== {32'h80000000, 3'b100})
      $display("FAIL ovf_result: got %h/%b%b%b required 80000000/100",
               rsp0_result, rsp0_overflow, rsp0_zero, rsp0_equal); else n_pass++;
    n_checks++; if ({rsp1_valid, rsp1_result} !== 33'd0)
      $display("FAIL ovf_other_channel: got %h required 0", {rsp1_valid, rsp1_result}); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0)
      $display("FAIL ovf_return_idle: busy=%b rv0=%b required 0 0", busy, rsp0_valid); else n_pass++;
    rsp0_ready = 0;
  endtask

  task automatic test_simultaneous();
    bit ok; int cyc; bit found;
    apply_reset();
    @(negedge clk);
    req0_a = 5; req0_b = 5; req0_control = ALU_SUB; req0_valid = 1;
    req1_a = 2; req1_b = 3; req1_control = ALU_ADD; req1_valid = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL sim_first_grant: ready0/1=%b required 10", {req0_ready, req1_ready}); else n_pass++;
    @(posedge clk); #1;
    req0_valid = 0;
    wait_rsp(0, ok, cyc);
    n_checks++; if (!ok || {rsp0_result, rsp0_zero, rsp0_equal} !== {32'd0, 2'b11})
      $display("FAIL sim_rsp0: seen=%0d got %h/%b%b required 0/11",
               ok, rsp0_result, rsp0_zero, rsp0_equal); else n_pass++;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (req1_ready) found = 1;
    end
    n_checks++; if (!found) $display("FAIL sim_second_grant: req1 ready got 0 required 1"); else n_pass++;
    @(posedge clk); #1;
    req1_valid = 0;
    wait_rsp(1, ok, cyc);
    n_checks++; if (!ok || rsp1_result !== 32'd5)
      $display("FAIL sim_rsp1: seen=%0d got %h required 5", ok, rsp1_result); else n_pass++;
    m_prio = 0;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int ngr = 0, dual = 0, g, pk = 0;
    bit pend = 0;
    logic [31:0] exp_r; logic exp_ov; logic [31:0] act_r; logic act_ov;
    @(negedge clk);
    req0_a = rand_operand(); req0_b = rand_operand(); req0_control = alu_control_t'($urandom_range(0, 5));
    req1_a = rand_operand(); req1_b = rand_operand(); req1_control = alu_control_t'($urandom_range(0, 5));
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int cyc = 0; cyc < 200 && !(ngr == 6 && !pend); cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (req0_ready && req1_ready) dual++;
      if (rsp0_valid || rsp1_valid) begin
        act_r  = rsp1_valid ? rsp1_result : rsp0_result;
        act_ov = rsp1_valid ? rsp1_overflow : rsp0_overflow;
        n_checks++; if (!pend || int'(rsp1_valid) != pk || act_r !== exp_r || act_ov !== exp_ov)
          $display("FAIL b2b_result: ch%0d got %h/%b required ch%0d %h/%b",
                   rsp1_valid, act_r, act_ov, pk, exp_r, exp_ov); else n_pass++;
        pend = 0;
      end
      if (ngr < 6 && (req0_ready || req1_ready)) begin
        g = req0_ready ? 0 : 1;
        n_checks++; if (g != int'(m_prio))
          $display("FAIL b2b_order: grant %0d got %0d required %0d", ngr, g, m_prio); else n_pass++;
        if (g == 0) ref_alu(req0_a, req0_b, int'(req0_control), exp_r, exp_ov);
        else        ref_alu(req1_a, req1_b, int'(req1_control), exp_r, exp_ov);
        pend = 1; pk = g; m_prio = (g == 0); ngr++;
        @(posedge clk); #1;
        if (ngr == 6) begin
          req0_valid = 0; req1_valid = 0;
        end else if (g == 0) begin
          req0_a = rand_operand(); req0_b = rand_operand(); req0_control = alu_control_t'($urandom_range(0, 5));
        end else begin
          req1_a = rand_operand(); req1_b = rand_operand(); req1_control = alu_control_t'($urandom_range(0, 5));
        end
      end
    end
    n_checks++; if (ngr != 6 || pend)
      $display("FAIL b2b_count: grants %0d pending %0d required 6 0", ngr, pend); else n_pass++;
    n_checks++; if (dual != 0)
      $display("FAIL b2b_dual_ready: cycles %0d required 0", dual); else n_pass++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_stall();
    bit ok; int cyc, bad = 0;
    logic [31:0] a, b, exp_r, cap_r; logic exp_ov; logic [2:0] cap_f;
    a = rand_operand(); b = rand_operand();
    ref_alu(a, b, 0, exp_r, exp_ov);
    rsp1_ready = 0;
    send(1, a, b, ALU_ADD, ok);
    req0_valid = 1;
    wait_rsp(1, ok, cyc);
    n_checks++; if (!ok || rsp1_result !== exp_r || rsp1_overflow !== exp_ov)
      $display("FAIL stall_result: got %h/%b required %h/%b", rsp1_result, rsp1_overflow, exp_r, exp_ov); else n_pass++;
    cap_r = rsp1_result; cap_f = {rsp1_overflow, rsp1_zero, rsp1_equal};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp1_result !== cap_r || {rsp1_overflow, rsp1_zero, rsp1_equal} !== cap_f ||
          rsp1_valid !== 1'b1 || busy !== 1'b1 || req0_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL stall_hold: unstable cycles %0d required 0", bad); else n_pass++;
    req0_valid = 0; rsp1_ready = 1;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || rsp1_valid !== 1'b0)
      $display("FAIL stall_release: busy=%b rv1=%b required 0 0", busy, rsp1_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_exec();
    bit ok; int cyc, bad = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    send(0, 32'd10, 32'd20, ALU_ADD, ok);
    req0_valid = 1; req1_valid = 1;
    #2 rst_n = 0;
    #1;
    n_checks++; if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0)
      $display("FAIL rst_exec_now: busy/rv0/rv1/rdy0/rdy1=%b required 00000",
               {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}); else n_pass++;
    @(negedge clk);
    rst_n = 1; req0_valid = 0; req1_valid = 0; m_prio = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (busy || rsp0_valid || rsp1_valid) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL rst_exec_after: stray cycles %0d required 0", bad); else n_pass++;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL rst_exec_prio: ready0/1=%b required 10", {req0_ready, req1_ready}); else n_pass++;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; m_prio = 1;
    wait_rsp(0, ok, cyc);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit out = 0; int since = 0, pk = 0;
    logic [31:0] exp_r, ea, eb; logic exp_ov;
    logic eg0, eg1, ev0, ev1;
    int done = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = rand_operand(); req0_b = rand_operand(); req0_control = alu_control_t'($urandom_range(0, 5));
      req1_a = rand_operand(); req1_b = rand_operand(); req1_control = alu_control_t'($urandom_range(0, 5));
      rsp0_ready = ($urandom_range(0, 3) != 0); rsp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out) since++;
      eg0 = !out && req0_valid && (!req1_valid || !m_prio);
      eg1 = !out && req1_valid && (!req0_valid ||  m_prio);
      ev0 = out && since >= 2 && pk == 0;
      ev1 = out && since >= 2 && pk == 1;
      n_checks++; if ({req0_ready, req1_ready} !== {eg0, eg1})
        $display("FAIL rnd_ready: cyc %0d got %b required %b", cyc, {req0_ready, req1_ready}, {eg0, eg1}); else n_pass++;
      n_checks++; if ({rsp0_valid, rsp1_valid} !== {ev0, ev1})
        $display("FAIL rnd_rsp_valid: cyc %0d got %b required %b", cyc, {rsp0_valid, rsp1_valid}, {ev0, ev1}); else n_pass++;
      if (ev0 || ev1) begin
        n_checks++;
        if ((ev0 ? rsp0_result : rsp1_result) !== exp_r ||
            (ev0 ? rsp0_overflow : rsp1_overflow) !== exp_ov ||
            (ev0 ? rsp0_zero : rsp1_zero) !== (exp_r == 0) ||
            (ev0 ? rsp0_equal : rsp1_equal) !== (ea == eb) ||
            (ev0 ? rsp1_result : rsp0_result) !== 32'd0)
          $display("FAIL rnd_rsp_data: cyc %0d ch%0d got %h/%b required %h/%b", cyc, pk,
                   ev0 ? rsp0_result : rsp1_result, ev0 ? rsp0_overflow : rsp1_overflow, exp_r, exp_ov);
        else n_pass++;
        if (ev0 ? rsp0_ready : rsp1_ready) begin out = 0; done++; end
      end else if (eg0 || eg1) begin
        pk = eg1 ? 1 : 0;
        ea = eg1 ? req1_a : req0_a; eb = eg1 ? req1_b : req0_b;
        ref_alu(ea, eb, eg1 ? int'(req1_control) : int'(req0_control), exp_r, exp_ov);
        out = 1; since = 0; m_prio = !eg1;
      end
    end
    n_checks++; if (done < 20) $display("FAIL rnd_progress: completed %0d required >=20", done); else n_pass++;
    // Drain any transaction still in flight.
    @(negedge clk);
    idle_inputs(); rsp0_ready = 1; rsp1_ready = 1;
    repeat (4) @(negedge clk);
    idle_inputs();
  endtask

`ifdef ALU_ARBITER_STATS_EN
  task automatic test_stats();
    bit ok; int cyc;
    apply_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 5; i++) begin
      send((i < 3) ? 0 : 1, $urandom, $urandom, ALU_XOR, ok);
      wait_rsp((i < 3) ? 0 : 1, ok, cyc);
    end
    @(negedge clk); #1;
    n_checks++; if (grant_count0 !== 16'd3 || grant_count1 !== 16'd2)
      $display("FAIL stats_counts: got %0d/%0d required 3/2", grant_count0, grant_count1); else n_pass++;
    idle_inputs();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_overflow_add();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_reset_mid_exec();
    test_random();
`ifdef ALU_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
